sub16_pipe: RTL and testbench
=============================

Name: sub16_pipe

Overview:
Pipelined 16-bit subtractor computing diff = a - b - bin. It is the inverse-direction counterpart of the team's carry-lookahead adder chain. Each stage resolves one 4-bit nibble through a borrow-lookahead slice and registers the inter-nibble borrow, which removes the 16-bit ripple path. Valid/ready handshakes on both sides allow it to sit between streaming producers and consumers in the datapath; it sustains one result per cycle.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of SLICE
SLICE, 4, bits resolved per pipeline stage
STAGES, WIDTH/SLICE (derived, 4), pipeline depth

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operand beat present
in_ready  out  1  block can accept operand beat this cycle
a  in  WIDTH  minuend
b  in  WIDTH  subtrahend
bin  in  1  borrow in
out_valid  out  1  result beat present
out_ready  in  1  consumer accepts result this cycle
diff  out  WIDTH  a - b - bin mod 2^WIDTH
bout  out  1  borrow out: 1 iff a < b + bin (unsigned)
ovf  out  1  signed overflow: (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB])
zero  out  1  diff == 0

Behaviour:
- Reset: asynchronous. While rst=1, all stage valid bits are 0, all stage data registers are 0, and out_valid, diff, bout, ovf and zero are 0. in_ready=0 while rst=1 and 1 after release (pipeline empty).
- Reset mid-operation: all in-flight beats are discarded. No beat in flight at assertion ever appears at the outputs.
- Arithmetic: computed as a + ~b + ~bin. Internal carry = ~borrow. Slice k takes nibble k of a and b plus the borrow from stage k-1 (stage 0 uses bin). It produces diff nibble k and the borrow into stage k+1. Final stage borrow = bout.
- Stage k register holds: valid_k; diff nibbles 0..k; borrow_k; upper nibbles k+1..MSB of a and b (skewed operands); a[MSB] and b[MSB] for the flags. Stage STAGES-1 is the output register; ovf and zero are computed combinationally into it.
- Handshake: ready_k = !valid_k | ready_{k+1}, with ready_{STAGES} = out_ready. in_ready = ready_0. A stage loads when its upstream is valid and ready_k=1.
- The in_ready to out_ready path is combinational; this is accepted for depth 4.
- Transfers: input accepted on an edge with in_valid & in_ready. Output consumed on an edge with out_valid & out_ready.
- Latency: beat accepted at edge N → out_valid=1 after edge N+3, with all other stalls 0.
- Throughput: one beat per cycle when out_ready is held 1.
- Backpressure: while out_ready=0, beats compact into empty stages. At most STAGES beats are held, after which in_ready=0.
- Outputs diff, bout, ovf and zero are stable while out_valid=1 and out_ready=0.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- Simultaneous accept and emit on a full pipe is legal and keeps occupancy constant.
- Inputs are ignored when in_valid=0. A bubble advances with valid=0; its data contents don't matter.

Decomposition:
- Package sub_pkg: WIDTH, SLICE, STAGES constants; a stage record typedef (valid, partial diff, borrow, skewed a/b, sign bits).
- Sub-module borrow_lookahead4 (combinational, SLICE=4), instantiated once per stage:
  - inputs: x[3:0], y[3:0], bi
  - outputs: d[3:0], bo
  - generate = x & ~y; propagate = ~(x ^ y)
  - borrow-lookahead equations, with no internal ripple.

Test Plan:
- a=0x1234, b=0x0234, bin=0, out_ready=1, accepted at edge N → after edge N+3: diff=0x1000, bout=0, ovf=0, zero=0, out_valid=1 for exactly one cycle.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0. Then a=0x5555, b=0x5554, bin=1 → diff=0x0000, zero=1, bout=0.
- a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1, bout=0. Then a=0x7FFF, b=0xFFFF → diff=0x8000, ovf=1, bout=1.
- Back-to-back: 8 random beats on consecutive cycles with out_ready=1 → 8 consecutive results, in order, matching the model; in_ready stays 1.
- Backpressure: out_ready=0, offer 6 beats → exactly 4 accepted, then in_ready=0 and outputs stable. Raise out_ready → remaining 2 accepted, all 6 emerge in order, no duplicates.
- Reset mid-stream: 3 beats in flight, pulse rst asynchronously between edges → out_valid and diff go to 0 immediately; after release no stale beat emerges and the first new beat has 4-cycle latency.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants and the per-stage pipeline record for the pipelined subtractor.
// Operands travel right-aligned, so the next slice always works on the low SLICE bits.
package sub_pkg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int STAGES = WIDTH / SLICE;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] diff;    // nibbles 0..k resolved, higher bits zero
    logic             borrow;  // borrow into the next slice
    logic [WIDTH-1:0] a_hi;    // unresolved minuend nibbles, shifted down
    logic [WIDTH-1:0] b_hi;    // unresolved subtrahend nibbles, shifted down
    logic             a_msb;
    logic             b_msb;
  } stage_t;

endpackage

// File: rtl/borrow_lookahead4.sv
// 4-bit borrow-lookahead slice: d = x - y - bi, computed as x + ~y + ~bi.
// Purely combinational; every carry is a flat sum of products, no internal ripple.
module borrow_lookahead4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = x & ~y;
  assign p = ~(x ^ y);

  // carry = ~borrow throughout
  assign c[0] = ~bi;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d  = p ^ c[3:0];
  assign bo = ~c[4];

endmodule

// File: rtl/sub16_pipe.sv
// Pipelined a - b - bin, one nibble per stage; 4-cycle latency, one result per cycle.
// Stalls compact into empty stages; in_ready drops only once all stages are full.
module sub16_pipe
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  stage_t            stg [STAGES];
  stage_t            nxt [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic              ovf_r;
  logic              zero_r;
  logic              ovf_nxt;
  logic              zero_nxt;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_v;
    logic             up_bi;
    logic             up_am;
    logic             up_bm;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;
    logic [WIDTH-1:0] up_diff;
    logic [SLICE-1:0] d;
    logic             bo;

    if (k == 0) begin : g_head
      assign up_v    = in_valid;
      assign up_a    = a;
      assign up_b    = b;
      assign up_bi   = bin;
      assign up_am   = a[WIDTH-1];
      assign up_bm   = b[WIDTH-1];
      assign up_diff = '0;
    end else begin : g_body
      assign up_v    = stg[k-1].valid;
      assign up_a    = stg[k-1].a_hi;
      assign up_b    = stg[k-1].b_hi;
      assign up_bi   = stg[k-1].borrow;
      assign up_am   = stg[k-1].a_msb;
      assign up_bm   = stg[k-1].b_msb;
      assign up_diff = stg[k-1].diff;
    end

    borrow_lookahead4 u_bla (
      .x  (up_a[SLICE-1:0]),
      .y  (up_b[SLICE-1:0]),
      .bi (up_bi),
      .d  (d),
      .bo (bo)
    );

    assign nxt[k] = '{valid:  up_v,
                      diff:   up_diff | (WIDTH'(d) << (k * SLICE)),
                      borrow: bo,
                      a_hi:   up_a >> SLICE,
                      b_hi:   up_b >> SLICE,
                      a_msb:  up_am,
                      b_msb:  up_bm};

    // Stage k can take a beat if it or any stage downstream has a hole.
    assign vld[k] = stg[k].valid;
    assign rdy[k] = out_ready | ~(&vld[STAGES-1:k]);
  end

  assign ovf_nxt  = (nxt[STAGES-1].a_msb ^ nxt[STAGES-1].b_msb)
                  & (nxt[STAGES-1].a_msb ^ nxt[STAGES-1].diff[WIDTH-1]);
  assign zero_nxt = (nxt[STAGES-1].diff == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stg[k] <= '0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) stg[k] <= nxt[k];
      end
      if (rdy[STAGES-1]) begin
        ovf_r  <= ovf_nxt;
        zero_r <= zero_nxt;
      end
    end
  end

  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = stg[STAGES-1].valid;
  assign diff      = stg[STAGES-1].diff;
  assign bout      = stg[STAGES-1].borrow;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_sub16_pipe.sv
// Self-checking bench for sub16_pipe: directed vector table, latency/backpressure/reset
// sequences, and a randomized phase scored against an integer-arithmetic reference model.
module tb_sub16_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  sub16_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] ediff;
    logic        ebout;
    logic        eovf;
    logic        ezero;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  int   ntests = 0;
  int   nerr   = 0;
  int   nemit  = 0;
  res_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d errors=%0d", ntests, nerr);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    res_t r;
    int ux  = x;
    int uy  = y;
    int sx  = $signed(x);
    int sy  = $signed(y);
    int ib  = bi;
    int ur;
    int sr;
    ur   = ux - uy - ib;
    sr   = sx - sy - ib;
    r.d  = ur[15:0];
    r.bo = (ux < uy + ib);
    r.ov = (sr > 32767) || (sr < -32768);
    r.z  = (r.d == 16'h0000);
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [15:0] x, input logic [15:0] y, input logic bi);
    vec_t v;
    res_t r;
    r = model(x, y, bi);
    v = '{x, y, bi, r.d, r.bo, r.ov, r.z};
    return v;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: handshakes sampled mid-cycle, effective at the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) q.push_back(model(a, b, bin));
      if (out_valid && out_ready) begin
        res_t e;
        nemit++;
        chk("sb_emit_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_diff", diff, e.d);
          chk("sb_bout", bout, e.bo);
          chk("sb_ovf",  ovf,  e.ov);
          chk("sb_zero", zero, e.z);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    step();
    chk({nm, "_drain_empty"}, q.size(), 0);
  endtask

  // Single beat into an empty pipe: visible after the third edge past acceptance, for one cycle.
  task automatic one_beat(input vec_t v, input string nm);
    a = v.a; b = v.b; bin = v.bin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({nm, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    step();
    chk({nm, "_early1"}, out_valid, 0);
    step();
    chk({nm, "_early2"}, out_valid, 0);
    step();
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_diff"}, diff, v.ediff);
    chk({nm, "_bout"}, bout, v.ebout);
    chk({nm, "_ovf"},  ovf,  v.eovf);
    chk({nm, "_zero"}, zero, v.ezero);
    step();
    chk({nm, "_one_cycle"}, out_valid, 0);
  endtask

  initial begin
    vec_t        tbl[8];
    logic [15:0] bpa[6];
    logic [15:0] bpb[6];
    logic        bpc[6];
    res_t        head;
    int          acc;
    int          base;
    logic        took;

    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};

    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff",      diff,      0);
    chk("rst_flags",     {bout, ovf, zero}, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) one_beat(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back streaming
    out_ready = 1'b1;
    base = nemit;
    for (int i = 0; i < 8; i++) begin
      a = rnd16(); b = rnd16(); bin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      chk("b2b_in_ready", in_ready, 1);
      step();
    end
    drain("b2b");
    chk("b2b_count", nemit - base, 8);

    // Backpressure: fill while stalled, then release
    for (int i = 0; i < 6; i++) begin
      bpa[i] = rnd16(); bpb[i] = rnd16(); bpc[i] = 1'($urandom_range(0, 1));
    end
    head = model(bpa[0], bpb[0], bpc[0]);
    base = nemit;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 6);
      if (acc < 6) begin a = bpa[acc]; b = bpb[acc]; bin = bpc[acc]; end
      took = in_valid && in_ready;
      step();
      if (took) acc++;
    end
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head_diff", diff, head.d);
    step(); step();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_diff", diff, head.d);
    chk("bp_hold_flags", {bout, ovf, zero}, {head.bo, head.ov, head.z});
    out_ready = 1'b1;
    #1;
    chk("bp_full_passthru_ready", in_ready, 1);
    for (int c = 0; c < 10 && acc < 6; c++) begin
      in_valid = 1'b1;
      a = bpa[acc]; b = bpb[acc]; bin = bpc[acc];
      took = in_ready;
      step();
      if (took) acc++;
    end
    chk("bp_all_accepted", acc, 6);
    drain("bp");
    chk("bp_emit_count", nemit - base, 6);

    // Randomized traffic with random stalls
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = rnd16(); b = rnd16(); bin = 1'($urandom_range(0, 1));
      step();
    end
    drain("rand");

    // Reset with beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rnd16(); b = rnd16(); bin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_in_ready", in_ready, 0);
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_stale", out_valid, 0);
    end
    one_beat(mkvec(16'hABCD, 16'h1234, 1'b1), "post_rst");
    drain("final");

    $display("[TB] %0d tests run, %0d failed", ntests, nerr);
    $finish;
  end

endmodule
